// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one 8N1 UART transmitter among N byte streams.
// Grant 1 cycle after req_valid; uart_data_valid 1 cycle after the handshake; owner holds until its last byte completes.
module uart_tx_arbiter #(
    parameter int N            = 4,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   byte_done,
    output logic           msg_abort,
    output logic           busy,
    output logic           uart_data_valid,
    output logic [7:0]     uart_data_in,
    input  logic           uart_tx_active,
    input  logic           uart_tx_done
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, ISSUE, WAIT_START, WAIT_DONE, WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] own_q, own_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [7:0]    data_q, data_d;
    logic [N-1:0]  bdone_q, bdone_d;
    logic          abort_q, abort_d;

    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] own_next;
    logic [7:0]    own_data;
    logic          own_last;
    logic          own_vld;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return PW'(s);
    endfunction

    // First requester at or above ptr, wrapping modulo N.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!pick_vld && req_valid[rr_idx(ptr_q, k)]) begin
                pick_vld = 1'b1;
                pick_idx = rr_idx(ptr_q, k);
            end
        end
    end

    always_comb begin
        own_data = 8'h00;
        own_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                own_data = req_data[8*i +: 8];
                own_last = req_last[i];
            end
        end
    end

    assign own_vld  = |(grant_q & req_valid);
    assign own_next = rr_idx(own_q, 1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        data_d  = data_q;
        bdone_d = '0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = N'(1) << pick_idx;
                    own_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (own_vld) begin
                    data_d  = own_data;
                    last_d  = own_last;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else if (HOLD_TIMEOUT != 0 && cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    ptr_d   = own_next;
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (HOLD_TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISSUE:      state_d = WAIT_START;
            WAIT_START: if (uart_tx_active) state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (uart_tx_done) begin
                    bdone_d = grant_q;
                    state_d = WAIT_IDLE;
                end
            end
            // tx_done may stretch; only move on once it drops so byte_done stays single.
            WAIT_IDLE: begin
                if (!uart_tx_done) begin
                    if (last_q) begin
                        ptr_d   = own_next;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            data_q  <= 8'h00;
            bdone_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            bdone_q <= bdone_d;
            abort_q <= abort_d;
        end
    end

    assign req_ready       = (state_q == LOAD) ? (grant_q & req_valid) : '0;
    assign grant           = grant_q;
    assign byte_done       = bdone_q;
    assign msg_abort       = abort_q;
    assign busy            = (state_q != IDLE);
    assign uart_data_valid = (state_q == ISSUE);
    assign uart_data_in    = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: 8N1 transmitter model (4 clocks/bit), per-requester byte queues,
// and a message-level round-robin model predicting the order of bytes on the wire.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [N-1:0]   byte_done;
    logic           msg_abort;
    logic           busy;
    logic           uart_data_valid;
    logic [7:0]     uart_data_in;
    logic           uart_tx_active;
    logic           uart_tx_done;

    uart_tx_arbiter #(.N(N), .HOLD_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .byte_done(byte_done),
        .msg_abort(msg_abort), .busy(busy),
        .uart_data_valid(uart_data_valid), .uart_data_in(uart_data_in),
        .uart_tx_active(uart_tx_active), .uart_tx_done(uart_tx_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Transmitter model: start bit, 8 data bits LSB first, stop bit, 4 clocks each.
    int         done_len;
    logic       tx_run;
    logic [9:0] tx_sh;
    int         tx_bit, tx_bc, tx_dcnt;
    logic [7:0] tx_byte;
    logic       serial;

    always @(posedge clk) begin
        if (reset) begin
            tx_run <= 1'b0; tx_bit <= 0; tx_bc <= 0; tx_dcnt <= 0;
            tx_sh <= '1; tx_byte <= 8'h00;
        end else begin
            if (tx_dcnt > 0) tx_dcnt <= tx_dcnt - 1;
            if (tx_run) begin
                if (tx_bc == 3) begin
                    tx_bc <= 0;
                    if (tx_bit == 9) begin
                        tx_run  <= 1'b0;
                        tx_dcnt <= done_len;
                    end else begin
                        tx_bit <= tx_bit + 1;
                    end
                end else begin
                    tx_bc <= tx_bc + 1;
                end
            end else if (uart_data_valid) begin
                tx_run <= 1'b1; tx_bit <= 0; tx_bc <= 0;
                tx_byte <= uart_data_in;
                tx_sh <= {1'b1, uart_data_in, 1'b0};
            end
        end
    end

    assign uart_tx_active = tx_run;
    assign uart_tx_done   = (tx_dcnt != 0);
    assign serial         = tx_run ? tx_sh[tx_bit] : 1'b1;

    // Stimulus queues ({last, data}) and the reference model state.
    logic [8:0]  drv_q [N][$];
    logic [8:0]  mdl_q [N][$];
    logic [10:0] exp_wire [$];
    int          m_ptr = 0;
    int          exp_abort = 0;
    logic [N-1:0] hs_q = '0;
    logic [63:0] hist = '0;
    int          n_dv = 0, n_bd = 0, n_abort = 0;

    task automatic push_msg(input int r, input int nb, input logic [7:0] base, input bit end_last);
        logic [8:0] w;
        for (int k = 0; k < nb; k++) begin
            w = {(end_last && k == nb - 1), base + 8'(k)};
            drv_q[r].push_back(w);
            mdl_q[r].push_back(w);
        end
    endtask

    // Whole messages go out in round-robin order from m_ptr; a message that
    // runs dry before its last byte ends in an abort.
    task automatic predict();
        int own;
        bit fin;
        logic [8:0] w;
        forever begin
            own = -1;
            for (int k = 0; k < N; k++)
                if (own < 0 && mdl_q[(m_ptr + k) % N].size() > 0) own = (m_ptr + k) % N;
            if (own < 0) break;
            fin = 1'b0;
            while (!fin) begin
                if (mdl_q[own].size() == 0) begin
                    exp_abort++;
                    fin = 1'b1;
                end else begin
                    w = mdl_q[own].pop_front();
                    exp_wire.push_back({3'(own), w[7:0]});
                    if (w[8]) fin = 1'b1;
                end
            end
            m_ptr = (own + 1) % N;
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (drv_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Requester driver: inputs change 1 time unit after the active edge.
    initial begin
        logic [8:0] w;
        req_valid = '0; req_data = '0; req_last = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs_q[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
                if (drv_q[i].size() > 0) begin
                    w = drv_q[i][0];
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = w[7:0];
                    req_last[i] = w[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            hs_q = req_valid & req_ready;
            if (!reset) begin
                chk("ready_outside_grant", 64'(req_ready & ~grant), 64'(0));
                chk("grant_onehot", 64'($countones(grant) <= 1), 64'(1));
                if (grant != 0) chk("busy_when_owned", 64'(busy), 64'(1));
                if (uart_data_valid) begin
                    chk("data_valid_while_tx_busy", 64'(tx_run || tx_dcnt != 0), 64'(0));
                    n_dv++;
                    hist = {hist[59:0], 4'(oh2idx(grant))};
                    chk("wire_byte_expected", 64'(exp_wire.size() > 0), 64'(1));
                    if (exp_wire.size() > 0) begin
                        e = exp_wire.pop_front();
                        chk("wire_owner", 64'(oh2idx(grant)), 64'(e[10:8]));
                        chk("wire_data", 64'(uart_data_in), 64'(e[7:0]));
                    end
                end
                if (byte_done != 0) begin
                    chk("byte_done_owner", 64'(byte_done), 64'(grant));
                    n_bd++;
                end
                if (msg_abort) begin
                    chk("abort_clears_grant", 64'(grant), 64'(0));
                    n_abort++;
                end
                if (tx_run && tx_bit == 9 && tx_bc == 3)
                    chk("data_in_stable", 64'(uart_data_in), 64'(tx_byte));
            end
        end
    end

    task automatic end_phase(input string nm);
        int t;
        t = 0;
        while (t < 3000 && !(all_empty() && !busy && !tx_run && tx_dcnt == 0)) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_completes"}, 64'(t < 3000), 64'(1));
        repeat (3) @(negedge clk);
        chk({nm, "_wire_drained"}, 64'(exp_wire.size()), 64'(0));
        chk({nm, "_byte_done_per_byte"}, 64'(n_bd), 64'(n_dv));
        chk({nm, "_aborts"}, 64'(n_abort), 64'(exp_abort));
    endtask

    task automatic wait_for(input string nm, input int budget, input bit want_active);
        int t;
        t = 0;
        while ((want_active ? !uart_tx_active : !uart_tx_done) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_seen"}, 64'(t < budget), 64'(1));
    endtask

    initial begin
        int t, n, nb, bd2;
        bit exp_rdy;
        logic [9:0] frame;
        reset = 1'b1;
        done_len = 1;
        repeat (3) @(negedge clk);
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_dv", 64'(uart_data_valid), 64'(0));
        chk("rst_data_in", 64'(uart_data_in), 64'(0));
        chk("rst_byte_done", 64'(byte_done), 64'(0));
        chk("rst_abort", 64'(msg_abort), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // All four requesting, 2-byte messages, requester 0 has two messages.
        hist = '0;
        push_msg(0, 2, 8'h10, 1'b1);
        push_msg(0, 2, 8'h18, 1'b1);
        push_msg(1, 2, 8'h20, 1'b1);
        push_msg(2, 2, 8'h30, 1'b1);
        push_msg(3, 2, 8'h40, 1'b1);
        predict();
        end_phase("rr4");
        chk("rr4_owner_order", hist[39:0], 64'h00_1122_3300);

        // Single requester 1, one byte 0x55.
        push_msg(1, 1, 8'h55, 1'b1);
        predict();
        t = 0;
        while (!req_valid[1] && t < 10) begin @(negedge clk); t++; end
        @(negedge clk);
        chk("single_grant", 64'(grant), 64'(4'b0010));
        chk("single_ready", 64'(req_ready), 64'(4'b0010));
        @(negedge clk);
        chk("single_dv", 64'(uart_data_valid), 64'(1));
        chk("single_data", 64'(uart_data_in), 64'(8'h55));
        @(negedge clk);
        chk("single_dv_pulse", 64'(uart_data_valid), 64'(0));
        wait_for("single_tx_active", 20, 1'b1);
        frame = '0;
        for (int k = 0; k < 40; k++) begin
            if (k % 4 == 2) frame[k/4] = serial;
            @(negedge clk);
        end
        chk("single_serial_frame", 64'(frame), 64'(10'b10_1010_1010));
        nb = 0;
        for (int j = 0; j < 10; j++) begin
            if (byte_done[1]) nb++;
            @(negedge clk);
        end
        chk("single_byte_done_once", 64'(nb), 64'(1));
        chk("single_release", 64'(grant), 64'(0));
        end_phase("single");

        // Requester 2 sends 3 bytes while requester 0 waits.
        push_msg(2, 3, 8'hA0, 1'b1);
        push_msg(0, 1, 8'hB0, 1'b1);
        predict();
        bd2 = 0; exp_rdy = 1'b0; n = 0;
        begin
            bit prev_done;
            prev_done = 1'b0;
            while (n < 1000) begin
                @(negedge clk);
                n++;
                if (exp_rdy) begin
                    chk("next_ready_after_done_fall", 64'(req_ready), 64'(4'b0100));
                    exp_rdy = 1'b0;
                end
                if (byte_done[2]) bd2++;
                if (prev_done && !uart_tx_done && bd2 < 3) exp_rdy = 1'b1;
                prev_done = uart_tx_done;
                if (req_ready[0]) break;
            end
        end
        chk("r0_waits_for_r2_msg", 64'(bd2), 64'(3));
        end_phase("hold");

        // Owner 3 stalls after a non-last byte; timeout is 8 LOAD cycles.
        push_msg(3, 1, 8'hC3, 1'b0);
        predict();
        wait_for("abort_tx_done", 200, 1'b0);
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (msg_abort) break;
        end
        chk("abort_latency", 64'(n), 64'(10));
        chk("abort_grant", 64'(grant), 64'(0));
        end_phase("abort");

        // Stretched tx_done, next winner after the abort is requester 0.
        done_len = 2;
        hist = '0;
        nb = n_bd;
        push_msg(1, 2, 8'hD0, 1'b1);
        push_msg(0, 2, 8'hE0, 1'b1);
        predict();
        end_phase("long_done");
        chk("long_done_order", hist[15:0], 64'h0011);
        chk("long_done_pulses", 64'(n_bd - nb), 64'(4));
        done_len = 1;

        // Reset while the transmitter is mid-byte.
        push_msg(2, 2, 8'hF0, 1'b1);
        predict();
        wait_for("rst_mid_tx_active", 200, 1'b1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            mdl_q[i].delete();
        end
        exp_wire.delete();
        m_ptr = 0; exp_abort = 0; n_dv = 0; n_bd = 0; n_abort = 0;
        @(negedge clk);
        chk("midrst_grant", 64'(grant), 64'(0));
        chk("midrst_ready", 64'(req_ready), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_dv", 64'(uart_data_valid), 64'(0));
        chk("midrst_data_in", 64'(uart_data_in), 64'(0));
        chk("midrst_byte_done", 64'(byte_done), 64'(0));
        chk("midrst_abort", 64'(msg_abort), 64'(0));
        reset = 1'b0;
        hist = '0;
        push_msg(3, 1, 8'h13, 1'b1);
        push_msg(1, 1, 8'h11, 1'b1);
        push_msg(0, 1, 8'h10, 1'b1);
        predict();
        end_phase("after_reset");
        chk("after_reset_order", hist[11:0], 64'h013);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one `uart_transmitter` (8N1, `data_valid` / `tx_active` / `tx_done` interface) between N byte-stream requesters.
- Each requester offers bytes with a valid/ready handshake and marks the final byte of a message with a `last` flag.
- Round-robin arbitration is performed per message. The owner holds the transmitter until its last byte completes, so messages are never interleaved on the wire.
- Sits between the system's message sources (status reporter, debug console, etc.) and the UART TX pin driver.

Parameters:
- N, 4, number of requesters (2..8).
- HOLD_TIMEOUT, 1024, cycles the owner may leave `req_valid` low mid-message before the grant is revoked; 0 = never revoke.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- req_valid  input  N  per-requester byte available
- req_data  input  8*N  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  input  N  per-requester "this byte ends the message"
- req_ready  output  N  byte accepted this cycle (one-hot or zero)
- grant  output  N  one-hot current message owner; 0 when unowned
- byte_done  output  N  1-cycle pulse to the owner when its byte's stop bit completes
- msg_abort  output  1  1-cycle pulse when an owner is revoked by timeout
- busy  output  1  high whenever state != IDLE
- uart_data_valid  output  1  to transmitter `data_valid`; exactly 1-cycle pulse per byte
- uart_data_in  output  8  to transmitter `data_in`; stable from capture until the byte completes
- uart_tx_active  input  1  from transmitter `tx_active`
- uart_tx_done  input  1  from transmitter `tx_done` (may stay high for more than one cycle)

Behaviour:
- Reset (clk edge with reset=1) forces:
  - all outputs to 0, including `uart_data_valid=0`, `uart_data_in=8'h00`, `grant=0`.
  - state to IDLE, round-robin pointer `ptr` to 0, timeout counter to 0, `last_q` to 0.
  - Reset mid-byte does not wait for the transmitter; the transmitter shares the same reset.
- State machine, all registered; `req_ready` is decoded combinationally from state and grant.
- IDLE:
  - If any `req_valid`, select the first index with `req_valid` set, searching from `ptr` upward modulo N.
  - Load `grant` with that index, go to LOAD. Otherwise stay.
- LOAD:
  - `req_ready = grant & req_valid`.
  - On handshake: capture the byte into `uart_data_in`, capture `req_last` into `last_q`, clear the timeout counter, go to ISSUE.
  - Without `req_valid` from the owner: increment the timeout counter.
  - If HOLD_TIMEOUT != 0 and the counter reaches HOLD_TIMEOUT-1: pulse `msg_abort`, set `ptr = owner+1 mod N`, clear `grant`, go to IDLE.
  - Other requesters' `req_valid` are ignored while owned.
- ISSUE: `uart_data_valid=1` for this cycle only; go to WAIT_START.
- WAIT_START: wait for `uart_tx_active=1`, then go to WAIT_DONE.
- WAIT_DONE: on `uart_tx_done=1`, pulse `byte_done[owner]` once and go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait for `uart_tx_done=0`, i.e. the transmitter is back in its idle state.
  - If `last_q`: set `ptr = owner+1 mod N`, clear `grant`, go to IDLE.
  - Otherwise: go to LOAD with the same owner.
- Latency:
  - `req_valid` asserted in cycle t from IDLE gives `grant` and `req_ready` in t+1.
  - `uart_data_valid` follows in t+2.
  - Back-to-back bytes of one message: the next `req_ready` comes 1 cycle after `uart_tx_done` falls.
- `grant` stays constant from LOAD entry until the return to IDLE.
- `ptr` changes only on message completion or abort, so a continuously requesting source cannot starve others.
- Simultaneous requests in IDLE are resolved purely by `ptr` order.
- A requester dropping `req_valid` in IDLE simply loses the arbitration round. No state is kept for it.
- `req_last` is sampled only at handshake.
- A one-byte message (last=1 on the first byte) releases after a single byte.
- `byte_done` fires exactly once per byte, even if `uart_tx_done` stays high 2+ cycles.

Test Plan:
- Single requester 1, one byte 0x55 with last=1, transmitter BAUD_VAL=4:
  - `grant=4'b0010` 1 cycle after `req_valid`; `uart_data_valid` pulses once with `data_in=0x55`.
  - Serial line shows 0,1,0,1,0,1,0,1,0,1 (4 clocks each).
  - `byte_done[1]` pulses once; `grant` then returns to 0.
- All 4 requesters valid continuously, 2-byte messages:
  - Owners cycle 0,1,2,3,0 in that order.
  - Wire carries each message's 2 bytes contiguously, never interleaved.
- Requester 2 sends 3 bytes while requester 0 asserts valid throughout:
  - Requester 0 gets `req_ready` only after requester 2's third byte (last) completes.
- HOLD_TIMEOUT=8; owner 3 sends byte 1 (last=0), then drops valid:
  - `msg_abort` pulses after 8 LOAD cycles; `grant` goes to 0; next winner is index 0 (`ptr` = 0).
- Model `uart_tx_done` high for 2 cycles: `byte_done` pulses exactly once per byte; no duplicate `uart_data_valid`.
- Reset asserted during WAIT_DONE: next cycle all outputs are 0 and state is IDLE; after release, requester 0 wins first (`ptr=0`).
